// File: rtl/simon_pattern_player.sv
// Simon pattern player: fetches each stored colour from the pattern RAM and
// lights the matching LED for an ON phase followed by a dark OFF phase.
module simon_pattern_player #(
  parameter int CLK_PER_TICK = 500000,
  parameter int ON_TICKS     = 50,
  parameter int OFF_TICKS    = 25,
  parameter int MAX_LEN      = 32,
  parameter int LEN_W        = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [LEN_W-1:0] length_i,
  input  logic             abort_i,
  output logic [LEN_W-1:0] rd_addr_o,
  input  logic [1:0]       rd_data_i,
  output logic [3:0]       led_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_ON    = 3'd3,
    S_OFF   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int PRE_W  = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_TICK - 1);
  localparam logic [PH_W-1:0]  ON_LAST   = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]  OFF_LAST  = PH_W'(OFF_TICKS - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  addr_q, addr_d;
  logic [1:0]        col_q, col_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [PH_W-1:0]   ph_q, ph_d;

  logic [LEN_W-1:0]  len_clamp;
  logic              tick;
  logic              phase_last;
  logic              last_step;

  assign len_clamp  = (length_i > MAX_LEN_V) ? MAX_LEN_V : length_i;
  assign tick       = (pre_q == PRE_LAST);
  assign phase_last = (state_q == S_ON) ? (ph_q == ON_LAST) : (ph_q == OFF_LAST);
  assign last_step  = (idx_q == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      col_q   <= '0;
      pre_q   <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      pre_q   <= pre_d;
      ph_q    <= ph_d;
    end
  end

  // Timebase counters default to 0, so every state change into ON or OFF
  // starts its phase from a clean count.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    col_d   = col_q;
    pre_d   = '0;
    ph_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          len_d = len_clamp;
          idx_d = '0;
          if (len_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        col_d   = rd_data_i;
        state_d = S_ON;
      end
      S_ON, S_OFF: begin
        if (tick) begin
          if (phase_last) begin
            if (state_q == S_ON) begin
              state_d = S_OFF;
            end else if (last_step) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + LEN_W'(1);
              addr_d  = idx_q + LEN_W'(1);
              state_d = S_FETCH;
            end
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
          ph_d  = ph_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort outranks both a fresh start and a phase completion this cycle.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      addr_d  = addr_q;
      pre_d   = '0;
      ph_d    = '0;
    end
  end

  assign rd_addr_o = addr_q;
  assign led_o     = (state_q == S_ON) ? (4'b0001 << col_q) : 4'b0000;
  assign busy_o    = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                     (state_q == S_ON)    || (state_q == S_OFF);
  assign done_o    = (state_q == S_DONE);
  assign state_o   = state_q;

endmodule

// File: tb/tb_simon_pattern_player.sv
// Directed bench for simon_pattern_player with a timeline model of playback
// (step number and offset derived from cycles since start).
module tb_simon_pattern_player;

  localparam int STEP = 22;
  localparam int MAXL = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [3:0] length_i;
  logic       abort_i;
  logic [3:0] rd_addr_o;
  logic [1:0] rd_data_i;
  logic [3:0] led_o;
  logic       busy_o;
  logic       done_o;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s0    = 0;
  bit chk_en = 1'b0;

  simon_pattern_player #(
    .CLK_PER_TICK(4), .ON_TICKS(3), .OFF_TICKS(2), .MAX_LEN(8), .LEN_W(4)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .length_i(length_i),
    .abort_i(abort_i), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .led_o(led_o), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] pat(input int i);
    case (i % 4)
      0: return 2'd2;
      1: return 2'd0;
      2: return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  // Pattern RAM with one-cycle read latency
  always @(posedge clk or posedge reset) begin
    if (reset) rd_data_i <= 2'd0;
    else       rd_data_i <= pat(int'(rd_addr_o));
  end

  // Playback model: active flag, cycles since start, clamped length, last fetch address
  bit         m_act;
  int         m_t;
  int         m_len;
  logic [3:0] m_addr;

  always @(posedge clk or posedge reset) begin : model
    bit         a;
    int         t;
    int         l;
    logic [3:0] ad;
    if (reset) begin
      m_act  <= 1'b0;
      m_t    <= 0;
      m_len  <= 0;
      m_addr <= 4'd0;
    end else begin
      a = m_act; t = m_t; l = m_len; ad = m_addr;
      if (!a) begin
        if (start_i && !abort_i) begin
          l = (int'(length_i) > MAXL) ? MAXL : int'(length_i);
          t = 1;
          a = 1'b1;
        end
      end else if (abort_i || t == l * STEP + 1) begin
        a = 1'b0;
      end else begin
        t = t + 1;
      end
      if (a && t <= l * STEP && ((t - 1) % STEP) == 0) ad = 4'((t - 1) / STEP);
      m_act <= a; m_t <= t; m_len <= l; m_addr <= ad;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_led;
    int         off;
    if (!reset && chk_en) begin
      e_busy = m_act && (m_t <= m_len * STEP);
      e_done = m_act && (m_t == m_len * STEP + 1);
      off    = (m_t - 1) % STEP;
      e_led  = (e_busy && off >= 2 && off <= 13) ? 4'(4'b0001 << pat((m_t - 1) / STEP)) : 4'b0000;
      check("m_busy", 32'(busy_o), 32'(e_busy));
      check("m_done", 32'(done_o), 32'(e_done));
      check("m_led", 32'(led_o), 32'(e_led));
      check("m_addr", 32'(rd_addr_o), 32'(m_addr));
    end
  end

  task automatic at_cycle(input int k);
    while (cyc != s0 + k) @(negedge clk);
  endtask

  task automatic begin_run(input logic [3:0] len);
    s0 = cyc;
    start_i = 1'b1;
    length_i = len;
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; length_i = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_addr", 32'(rd_addr_o), 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Normal 3-step run
    begin_run(4'd3);
    at_cycle(1);  start_i = 1'b0;
    check("n_busy1", 32'(busy_o), 32'h1);
    check("n_addr0", 32'(rd_addr_o), 32'h0);
    at_cycle(3);  check("n_led3", 32'(led_o), 32'h4);
    at_cycle(14); check("n_led14", 32'(led_o), 32'h4);
    at_cycle(15); check("n_led15", 32'(led_o), 32'h0);
    at_cycle(23); check("n_addr1", 32'(rd_addr_o), 32'h1);
    at_cycle(25); check("n_led25", 32'(led_o), 32'h1);
    at_cycle(45); check("n_addr2", 32'(rd_addr_o), 32'h2);
    at_cycle(47); check("n_led47", 32'(led_o), 32'h8);
    at_cycle(66); check("n_busy66", 32'(busy_o), 32'h1);
    at_cycle(67);
    check("n_done67", 32'(done_o), 32'h1);
    check("n_busy67", 32'(busy_o), 32'h0);
    at_cycle(68); check("n_done68", 32'(done_o), 32'h0);
    at_cycle(70);

    // Zero length
    begin_run(4'd0);
    at_cycle(1); start_i = 1'b0;
    check("z_done1", 32'(done_o), 32'h1);
    check("z_busy1", 32'(busy_o), 32'h0);
    at_cycle(2); check("z_done2", 32'(done_o), 32'h0);
    at_cycle(4);

    // Abort while start held high, abort in IDLE, then restart
    begin_run(4'd3);
    at_cycle(15); abort_i = 1'b1;
    at_cycle(16);
    check("a_busy16", 32'(busy_o), 32'h0);
    check("a_led16", 32'(led_o), 32'h0);
    check("a_done16", 32'(done_o), 32'h0);
    at_cycle(17);
    abort_i = 1'b0;
    check("a_busy17", 32'(busy_o), 32'h0);
    begin_run(4'd2);
    at_cycle(1); start_i = 1'b0;
    check("r_busy1", 32'(busy_o), 32'h1);
    check("r_addr0", 32'(rd_addr_o), 32'h0);
    at_cycle(45); check("r_done45", 32'(done_o), 32'h1);
    at_cycle(47);

    // Clamp to MAX_LEN and ignored second start
    begin_run(4'd12);
    at_cycle(1);   start_i = 1'b0;
    at_cycle(40);  start_i = 1'b1; length_i = 4'd1;
    at_cycle(41);  start_i = 1'b0;
    at_cycle(155); check("c_addr7", 32'(rd_addr_o), 32'h7);
    at_cycle(176);
    check("c_busy176", 32'(busy_o), 32'h1);
    check("c_done176", 32'(done_o), 32'h0);
    at_cycle(177); check("c_done177", 32'(done_o), 32'h1);
    at_cycle(179);

    // Abort on the very last OFF cycle
    begin_run(4'd2);
    at_cycle(1);  start_i = 1'b0;
    at_cycle(44);
    abort_i = 1'b1;
    check("p_busy44", 32'(busy_o), 32'h1);
    at_cycle(45);
    abort_i = 1'b0;
    check("p_done45", 32'(done_o), 32'h0);
    check("p_busy45", 32'(busy_o), 32'h0);
    at_cycle(47); check("p_done47", 32'(done_o), 32'h0);

    // Asynchronous reset mid-playback
    begin_run(4'd3);
    at_cycle(1);  start_i = 1'b0;
    at_cycle(30);
    check("x_led30", 32'(led_o), 32'h1);
    check("x_addr30", 32'(rd_addr_o), 32'h1);
    reset = 1'b1;
    #1;
    check("x_led", 32'(led_o), 32'h0);
    check("x_busy", 32'(busy_o), 32'h0);
    check("x_done", 32'(done_o), 32'h0);
    check("x_addr", 32'(rd_addr_o), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      check("x_nodone", 32'(done_o), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
